// File: rtl/conv3x3_stream_engine_if.sv
// Column-stream and result-stream handshake bundle for conv3x3_stream_engine.
// master = engine side, slave = line-buffer / downstream side.
interface conv3x3_stream_engine_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
);
    logic              col_valid;
    logic              col_ready;
    logic [DATA_W-1:0] col_l1;
    logic [DATA_W-1:0] col_l2;
    logic [DATA_W-1:0] col_l3;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;

    modport master (
        input  col_valid, col_l1, col_l2, col_l3, out_ready,
        output col_ready, out_valid, out_data
    );

    modport slave (
        output col_valid, col_l1, col_l2, col_l3, out_ready,
        input  col_ready, out_valid, out_data
    );
endinterface

// File: rtl/conv3x3_stream_engine.sv
// 3x3 sliding-window convolution engine with runtime stride and kernel ROM load.
// Optional macro CONV_RELU_EN clamps negative results to zero in the output register.
module conv3x3_stream_engine #(
    parameter int DATA_W   = 8,
    parameter int KERNEL_W = 8,
    parameter int COLS_W   = 10,
    parameter int ACC_W    = DATA_W + KERNEL_W + 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 stride,
    input  logic [COLS_W-1:0]          num_cols,
    output logic [3:0]                 kernel_addr,
    input  logic signed [KERNEL_W-1:0] kernel_in,
    conv3x3_stream_engine_if.master    bus,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [2:0] {
        S_IDLE, S_KLOAD, S_FILL, S_MAC, S_OUT, S_SHIFT, S_DRAIN, S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [1:0]                 stride_q, stride_d;
    logic [COLS_W-1:0]          ncols_q, ncols_d;
    logic [COLS_W:0]            consumed_q, consumed_d;
    logic [DATA_W-1:0]          win_q [3][3];
    logic [DATA_W-1:0]          win_d [3][3];
    logic signed [KERNEL_W-1:0] w_q [3][3];
    logic signed [KERNEL_W-1:0] w_d [3][3];
    logic signed [ACC_W-1:0]    acc_q, acc_d, acc_sum, res;
    logic signed [ACC_W-1:0]    out_data_q, out_data_d;
    logic [3:0]                 kaddr_q, kaddr_d;
    logic                       col_ready_q, col_ready_d;
    logic                       out_valid_q, out_valid_d;
    logic                       busy_q, busy_d, done_q, done_d;
    logic                       col_acc;
    logic [DATA_W-1:0]          col_in [3];
    logic signed [ACC_W-1:0]    px [3];
    logic signed [ACC_W-1:0]    wx [3];
    logic [COLS_W:0]            ncols_ext, consumed_inc, consumed_next_win;

    assign kernel_addr   = kaddr_q;
    assign bus.col_ready = col_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;
    assign done          = done_q;

    assign col_acc           = col_ready_q & bus.col_valid;
    assign ncols_ext         = {1'b0, ncols_q};
    assign consumed_inc      = consumed_q + (COLS_W+1)'(1);
    assign consumed_next_win = consumed_q + (COLS_W+1)'(stride_q);

    // MAC always works on column 0; window and weights rotate so 3 cycles restore them.
    always_comb begin
        acc_sum = acc_q;
        for (int unsigned r = 0; r < 3; r++) begin
            px[r]   = ACC_W'({1'b0, win_q[r][0]});
            wx[r]   = ACC_W'(w_q[r][0]);
            acc_sum = acc_sum + px[r] * wx[r];
        end
`ifdef CONV_RELU_EN
        res = (acc_sum < 0) ? '0 : acc_sum;
`else
        res = acc_sum;
`endif
    end

    always_comb begin
        col_in[0] = bus.col_l1;
        col_in[1] = bus.col_l2;
        col_in[2] = bus.col_l3;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stride_d   = stride_q;
        ncols_d    = ncols_q;
        consumed_d = consumed_q;
        win_d      = win_q;
        w_d        = w_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_valid_d = out_valid_q;
        kaddr_d    = kaddr_q;

        case (state_q)
            S_IDLE: if (start) begin
                stride_d   = (stride == 2'd0) ? 2'd1 : stride;
                ncols_d    = num_cols;
                consumed_d = '0;
                cnt_d      = '0;
                kaddr_d    = '0;
                state_d    = S_KLOAD;
            end
            S_KLOAD: begin
                // Weights arrive one cycle behind the address; shift them in row-major order.
                if (cnt_q != 4'd0) begin
                    for (int unsigned r = 0; r < 3; r++) begin
                        w_d[r][0] = w_q[r][1];
                        w_d[r][1] = w_q[r][2];
                    end
                    w_d[0][2] = w_q[1][0];
                    w_d[1][2] = w_q[2][0];
                    w_d[2][2] = kernel_in;
                end
                kaddr_d = (cnt_q < 4'd8) ? cnt_q + 4'd1 : '0;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    cnt_d = '0;
                    if (ncols_q >= COLS_W'(3))       state_d = S_FILL;
                    else if (ncols_q != '0)          state_d = S_DRAIN;
                    else                             state_d = S_DONE;
                end
            end
            S_FILL, S_SHIFT: if (col_acc) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    win_d[r][0] = win_q[r][1];
                    win_d[r][1] = win_q[r][2];
                    win_d[r][2] = col_in[r];
                end
                consumed_d = consumed_inc;
                cnt_d      = cnt_q + 4'd1;
                if ((state_q == S_FILL && cnt_q == 4'd2) ||
                    (state_q == S_SHIFT && cnt_q + 4'd1 == {2'b00, stride_q})) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_sum;
                for (int unsigned r = 0; r < 3; r++) begin
                    win_d[r][0] = win_q[r][1];
                    win_d[r][1] = win_q[r][2];
                    win_d[r][2] = win_q[r][0];
                    w_d[r][0]   = w_q[r][1];
                    w_d[r][1]   = w_q[r][2];
                    w_d[r][2]   = w_q[r][0];
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd2) begin
                    cnt_d       = '0;
                    out_data_d  = res;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end
            end
            S_OUT: if (bus.out_ready) begin
                out_valid_d = 1'b0;
                cnt_d       = '0;
                if (consumed_next_win <= ncols_ext) state_d = S_SHIFT;
                else if (consumed_q < ncols_ext)    state_d = S_DRAIN;
                else                                state_d = S_DONE;
            end
            S_DRAIN: if (col_acc) begin
                consumed_d = consumed_inc;
                if (consumed_inc == ncols_ext) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        col_ready_d = (state_d == S_FILL) || (state_d == S_SHIFT) || (state_d == S_DRAIN);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            stride_q    <= 2'd1;
            ncols_q     <= '0;
            consumed_q  <= '0;
            win_q       <= '{default: '0};
            w_q         <= '{default: '0};
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            kaddr_q     <= '0;
            col_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stride_q    <= stride_d;
            ncols_q     <= ncols_d;
            consumed_q  <= consumed_d;
            win_q       <= win_d;
            w_q         <= w_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            kaddr_q     <= kaddr_d;
            col_ready_q <= col_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule
